// File: rtl/bp_me_mem_cmd_arbiter.sv
// Round-robin arbiter that shares one BedRock mem command/response channel
// among several requesters. The requester index of each forwarded command is
// kept in an order FIFO so that in-order responses are routed back to it.

module bp_me_mem_cmd_arbiter_checker #(
    parameter int num_req_p = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 mem_resp_v_i,
    input  logic                 fifo_empty_i,
    input  logic [num_req_p-1:0] resp_v_i,
    input  logic [num_req_p-1:0] resp_yumi_i
);

    // Flag responses with nothing outstanding and yumis from non-head requesters
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(mem_resp_v_i && fifo_empty_i))
                else $warning("mem response arrived with no outstanding command");
            assert ((resp_yumi_i & ~resp_v_i) == {num_req_p{1'b0}})
                else $error("response yumi from a requester that is not at the head");
        end
    end

endmodule

module bp_me_mem_cmd_arbiter #(
    parameter int num_req_p         = 2,
    parameter int msg_width_p       = 128,
    parameter int max_outstanding_p = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]             req_cmd_v_i,
    output logic [num_req_p-1:0]             req_cmd_ready_and_o,
    output logic [msg_width_p-1:0]           req_resp_o,
    output logic [num_req_p-1:0]             req_resp_v_o,
    input  logic [num_req_p-1:0]             req_resp_yumi_i,
    output logic [msg_width_p-1:0]           mem_cmd_o,
    output logic                             mem_cmd_v_o,
    input  logic                             mem_cmd_ready_and_i,
    input  logic [msg_width_p-1:0]           mem_resp_i,
    input  logic                             mem_resp_v_i,
    output logic                             mem_resp_yumi_o
);

    localparam int lg_req_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int lg_fifo_lp = $clog2(max_outstanding_p);
    localparam int cnt_w_lp   = $clog2(max_outstanding_p + 1);

    logic [lg_req_lp-1:0]   r_rr_ptr;
    logic [lg_req_lp-1:0]   r_order [max_outstanding_p];
    logic [lg_fifo_lp-1:0]  r_wptr;
    logic [lg_fifo_lp-1:0]  r_rptr;
    logic [cnt_w_lp-1:0]    r_count;

    logic [msg_width_p-1:0] w_req_cmd [num_req_p];
    logic [lg_req_lp-1:0]   w_grant;
    logic [lg_req_lp-1:0]   w_idx;
    logic                   w_found;
    logic [lg_req_lp-1:0]   w_head;
    logic [lg_req_lp-1:0]   w_rr_next;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;

    // Index rr_ptr + off, wrapped modulo the requester count
    function automatic logic [lg_req_lp-1:0] wrap_idx(input logic [lg_req_lp-1:0] base,
                                                      input int off);
        logic [lg_req_lp:0] sum;
        sum = {1'b0, base} + (lg_req_lp+1)'(off);
        if (sum >= (lg_req_lp+1)'(num_req_p)) begin
            sum = sum - (lg_req_lp+1)'(num_req_p);
        end else begin
            sum = sum;
        end
        return sum[lg_req_lp-1:0];
    endfunction

    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_unpack
        assign w_req_cmd[gi] = req_cmd_i[gi*msg_width_p +: msg_width_p];
    end

    assign w_full    = (r_count == cnt_w_lp'(max_outstanding_p));
    assign w_empty   = (r_count == {cnt_w_lp{1'b0}});
    assign w_head    = r_order[r_rptr];
    assign w_rr_next = (w_grant == lg_req_lp'(num_req_p - 1)) ? {lg_req_lp{1'b0}}
                                                              : w_grant + lg_req_lp'(1);
    assign w_push    = mem_cmd_v_o & mem_cmd_ready_and_i;
    assign w_pop     = mem_resp_yumi_o;

    // Round-robin grant: first valid requester at or after rr_ptr
    always_comb begin
        w_grant = r_rr_ptr;
        w_found = 1'b0;
        w_idx   = r_rr_ptr;
        for (int k = 0; k < num_req_p; k++) begin
            w_idx = wrap_idx(r_rr_ptr, k);
            if (!w_found && req_cmd_v_i[w_idx]) begin
                w_grant = w_idx;
                w_found = 1'b1;
            end else begin
                w_grant = w_grant;
                w_found = w_found;
            end
        end
    end

    // Command forwarding and response routing; full stalls without pop bypass
    always_comb begin
        mem_cmd_o   = w_req_cmd[w_grant];
        mem_cmd_v_o = (|req_cmd_v_i) & ~w_full & ~reset_i;
        req_cmd_ready_and_o = {num_req_p{1'b0}};
        if (!reset_i && !w_full && mem_cmd_ready_and_i) begin
            req_cmd_ready_and_o[w_grant] = 1'b1;
        end else begin
            req_cmd_ready_and_o = {num_req_p{1'b0}};
        end
        req_resp_o   = mem_resp_i;
        req_resp_v_o = {num_req_p{1'b0}};
        if (mem_resp_v_i && !w_empty && !reset_i) begin
            req_resp_v_o[w_head] = 1'b1;
        end else begin
            req_resp_v_o = {num_req_p{1'b0}};
        end
        mem_resp_yumi_o = req_resp_yumi_i[w_head] & req_resp_v_o[w_head];
    end

    // Round-robin pointer, order FIFO pointers and occupancy count
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rr_ptr <= {lg_req_lp{1'b0}};
            r_wptr   <= {lg_fifo_lp{1'b0}};
            r_rptr   <= {lg_fifo_lp{1'b0}};
            r_count  <= {cnt_w_lp{1'b0}};
        end else begin
            if (w_push) begin
                r_wptr   <= r_wptr + lg_fifo_lp'(1);
                r_rr_ptr <= w_rr_next;
            end else begin
                r_wptr   <= r_wptr;
                r_rr_ptr <= r_rr_ptr;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + lg_fifo_lp'(1);
            end else begin
                r_rptr <= r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + cnt_w_lp'(1);
                2'b01:   r_count <= r_count - cnt_w_lp'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Order FIFO storage: requester index of each forwarded command
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_order[r_wptr] <= w_grant;
        end else begin
            r_order[r_wptr] <= r_order[r_wptr];
        end
    end

    bp_me_mem_cmd_arbiter_checker #(
        .num_req_p (num_req_p)
    ) u_checker (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .mem_resp_v_i (mem_resp_v_i),
        .fifo_empty_i (w_empty),
        .resp_v_i     (req_resp_v_o),
        .resp_yumi_i  (req_resp_yumi_i)
    );

endmodule
